reg_bank_arbiter: RTL and testbench

Shared register bank, NUM_REGS x DATA_W, with per-register reset values. NUM_REQ requesters access it through a round-robin arbiter with valid/ready handshake and optional bus locking. It serves one transaction per cycle and returns read data one cycle later. It sits between control agents and the datapath, which consumes the bank contents on the regs_out bus.

---
 rtl/reg_bank_pkg.sv | 15 +
 rtl/reg_bank_arbiter_rr.sv | 32 +++
 rtl/reg_bank_arbiter.sv | 134 +++++++++++++
 tb/tb_reg_bank_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the arbitrated register bank.
package reg_bank_pkg;

    // The arbiter is either free for round-robin selection or held by one owner
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits, even for tiny counts
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    // Walk the requesters cyclically from ptr and grant the first one that is valid
    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shared register bank with round-robin, lockable access from several requesters.
// One transaction per cycle; read data returns one cycle after acceptance.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int                         NUM_REQ   = 4,
    parameter int                         NUM_REGS  = 8,
    parameter int                         DATA_W    = 8,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VEC = '0,
    localparam int                        ADDR_W    = clog2_min1(NUM_REGS),
    localparam int                        ID_W      = clog2_min1(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ-1:0]           req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [ID_W-1:0]              grant_id,
    output logic                         locked,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out
);

    arb_state_t                       state;
    logic [ID_W-1:0]                  rr_ptr;
    logic [ID_W-1:0]                  owner;
    logic [NUM_REGS-1:0][DATA_W-1:0]  bank;

    logic [NUM_REQ-1:0]               arb_grant;
    logic [ID_W-1:0]                  arb_idx;
    logic [ID_W-1:0]                  acc_idx;
    logic [ID_W-1:0]                  next_ptr;
    logic                             accept;
    logic                             sel_write;
    logic                             sel_lock;
    logic [ADDR_W-1:0]                sel_addr;
    logic [DATA_W-1:0]                sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Grant: round-robin when free, only the owner (and only if it asks) when locked
    always_comb begin
        req_ready = '0;
        if (!rst) begin
            if (state == IDLE) begin
                req_ready = arb_grant;
            end else if (req_valid[owner]) begin
                req_ready[owner] = 1'b1;
            end
        end
    end

    assign accept   = |req_ready;
    assign acc_idx  = (state == IDLE) ? arb_idx : owner;
    assign next_ptr = (acc_idx == ID_W'(NUM_REQ - 1)) ? '0 : acc_idx + ID_W'(1);
    assign locked   = (state == LOCKED);
    assign regs_out = bank;

    // Route the granted requester's command fields onto a single internal bus
    always_comb begin
        sel_write = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_write = req_write[i];
                sel_lock  = req_lock[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Bank storage: full-width write of the accepted transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            bank <= RESET_VEC;
        end else if (accept && sel_write) begin
            bank[sel_addr] <= sel_wdata;
        end
    end

    // Lock FSM, round-robin pointer and the registered read response
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            grant_id  <= '0;
        end else begin
            rsp_valid <= accept && !sel_write;
            if (accept) begin
                grant_id <= acc_idx;
                rr_ptr   <= next_ptr;
                if (!sel_write) begin
                    rsp_id   <= acc_idx;
                    rsp_data <= bank[sel_addr];
                end
                case (state)
                    IDLE: begin
                        if (sel_lock) begin
                            state <= LOCKED;
                            owner <= acc_idx;
                        end
                    end
                    LOCKED: begin
                        if (!sel_lock) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed test of reg_bank_arbiter: reset, round-robin, read/write, locking.
module tb_reg_bank_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int ID_W     = 2;
    localparam logic [NUM_REGS*DATA_W-1:0] RST_VEC = 64'h0000_0000_A500_0000;

    logic                           clk;
    logic                           rst;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0]             req_lock;
    logic [NUM_REQ*ADDR_W-1:0]      req_addr;
    logic [NUM_REQ*DATA_W-1:0]      req_wdata;
    logic                           rsp_valid;
    logic [ID_W-1:0]                rsp_id;
    logic [DATA_W-1:0]              rsp_data;
    logic [ID_W-1:0]                grant_id;
    logic                           locked;
    logic [NUM_REGS*DATA_W-1:0]     regs_out;

    int checks;
    int errors;

    reg_bank_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W),
        .RESET_VEC (RST_VEC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .grant_id  (grant_id),
        .locked    (locked),
        .regs_out  (regs_out)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic w, input logic l,
                                 input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[i] = v;
        req_write[i] = w;
        req_lock[i]  = l;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic clearAll();
        req_valid = '0;
        req_write = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clearAll();

        // 1. Reset: ready held low even with every requester valid
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        tick();
        tick();
        checkOutput("rst_ready", req_ready, 4'b0000);
        checkOutput("rst_regs", regs_out, RST_VEC);
        checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rst_locked", locked, 1'b0);
        checkOutput("rst_grant_id", grant_id, 2'd0);
        clearAll();
        rst = 1'b0;
        settle();

        // 2. Round-robin with all four writing reg i := 0x10+i
        for (int i = 0; i < NUM_REQ; i++)
            applyStimulus(i, 1'b1, 1'b1, 1'b0, 3'(i), 8'(8'h10 + i));
        settle();
        checkOutput("rr_ready0", req_ready, 4'b0001);
        tick();
        checkOutput("rr_ready1", req_ready, 4'b0010);
        checkOutput("rr_gid0", grant_id, 2'd0);
        tick();
        checkOutput("rr_ready2", req_ready, 4'b0100);
        checkOutput("rr_gid1", grant_id, 2'd1);
        tick();
        checkOutput("rr_ready3", req_ready, 4'b1000);
        checkOutput("rr_gid2", grant_id, 2'd2);
        tick();
        checkOutput("rr_wrap", req_ready, 4'b0001);
        checkOutput("rr_gid3", grant_id, 2'd3);
        req_valid = 4'b0100;
        settle();
        checkOutput("rr_only2_a", req_ready, 4'b0100);
        tick();
        checkOutput("rr_only2_b", req_ready, 4'b0100);
        tick();
        checkOutput("rr_only2_gid", grant_id, 2'd2);
        checkOutput("rr_regs", regs_out, 64'h0000_0000_1312_1110);

        // 3. Req1 writes reg5 then reads it back
        clearAll();
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'd5, 8'h3C);
        settle();
        checkOutput("wr_ready", req_ready, 4'b0010);
        tick();
        checkOutput("wr_reg5", regs_out[47:40], 8'h3C);
        checkOutput("wr_no_rsp", rsp_valid, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00);
        tick();
        checkOutput("rd_rsp_valid", rsp_valid, 1'b1);
        checkOutput("rd_rsp_id", rsp_id, 2'd1);
        checkOutput("rd_rsp_data", rsp_data, 8'h3C);
        clearAll();
        applyStimulus(3, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00);
        tick();
        checkOutput("rd3_rsp_id", rsp_id, 2'd3);
        checkOutput("rd3_rsp_data", rsp_data, 8'h13);
        clearAll();
        tick();
        checkOutput("rsp_pulse_end", rsp_valid, 1'b0);
        checkOutput("rsp_hold_data", rsp_data, 8'h13);

        // 4. Lock hold by req0 against contending req1/req3
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 3'd2, 8'h00);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00);
        applyStimulus(3, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        settle();
        checkOutput("lk_first", req_ready, 4'b0001);
        tick();
        checkOutput("lk_locked", locked, 1'b1);
        checkOutput("lk_rsp_data", rsp_data, 8'h12);
        checkOutput("lk_hold1", req_ready, 4'b0001);
        tick();
        checkOutput("lk_hold2", req_ready, 4'b0001);
        req_valid[0] = 1'b0;
        settle();
        checkOutput("lk_idle_ready", req_ready, 4'b0000);
        tick();
        checkOutput("lk_idle_locked", locked, 1'b1);
        checkOutput("lk_idle_rsp", rsp_valid, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'd6, 8'h5A);
        settle();
        checkOutput("lk_release_ready", req_ready, 4'b0001);
        tick();
        checkOutput("lk_released", locked, 1'b0);
        checkOutput("lk_reg6", regs_out[55:48], 8'h5A);
        req_valid[0] = 1'b0;
        settle();
        checkOutput("lk_next_req1", req_ready, 4'b0010);
        tick();
        checkOutput("lk_req1_id", rsp_id, 2'd1);
        checkOutput("lk_req1_data", rsp_data, 8'h11);

        // 5. Reset while req2 holds the lock with a read pending
        clearAll();
        applyStimulus(2, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00);
        settle();
        checkOutput("rl_grant2", req_ready, 4'b0100);
        tick();
        checkOutput("rl_locked", locked, 1'b1);
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00);
        req_lock[2] = 1'b1;
        rst = 1'b1;
        settle();
        checkOutput("rl_ready_in_rst", req_ready, 4'b0000);
        tick();
        rst = 1'b0;
        settle();
        checkOutput("rl_locked_clr", locked, 1'b0);
        checkOutput("rl_rsp_valid", rsp_valid, 1'b0);
        checkOutput("rl_regs", regs_out, RST_VEC);
        checkOutput("rl_rr_ptr0", req_ready, 4'b0001);

        // 6. Read right after a write to the same register, and read on release
        clearAll();
        applyStimulus(3, 1'b1, 1'b1, 1'b0, 3'd0, 8'hFF);
        settle();
        checkOutput("adj_wr_ready", req_ready, 4'b1000);
        tick();
        clearAll();
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        settle();
        checkOutput("adj_rd_ready", req_ready, 4'b0100);
        tick();
        checkOutput("adj_rsp_valid", rsp_valid, 1'b1);
        checkOutput("adj_rsp_id", rsp_id, 2'd2);
        checkOutput("adj_rsp_data", rsp_data, 8'hFF);
        clearAll();
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00);
        tick();
        checkOutput("rel_lock_data", rsp_data, 8'hA5);
        checkOutput("rel_locked", locked, 1'b1);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00);
        settle();
        checkOutput("rel_owner_only", req_ready, 4'b0010);
        tick();
        checkOutput("rel_unlocked", locked, 1'b0);
        checkOutput("rel_rsp_valid", rsp_valid, 1'b1);
        checkOutput("rel_rsp_id", rsp_id, 2'd1);
        checkOutput("rel_rsp_data", rsp_data, 8'hFF);
        checkOutput("rel_gid", grant_id, 2'd1);
        req_valid[1] = 1'b0;
        settle();
        checkOutput("rel_next", req_ready, 4'b0001);
        clearAll();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
